// File: rtl/pkg_multiplicador.sv
// Shared types and key codes for the keypad-to-multiplier operand path.
package pkg_multiplicador;

  // Operand entry sequencer states; encoding is exported on debug LEDs.
  typedef enum logic [2:0] {
    CAPT_A = 3'd0,
    CAPT_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SHOW   = 3'd4
  } estado_t;

  // Keypad decoder codes for the two non-digit keys ('*' and '#').
  localparam logic [3:0] TECLA_CLEAR = 4'd10;
  localparam logic [3:0] TECLA_ENTER = 4'd11;

endpackage

// File: rtl/module_acum_decimal.sv
// One decimal operand accumulator with a saturating digit counter.
// Priority: clear, then load-first-digit, then ordinary digit append.
module module_acum_decimal #(
  parameter int N_DIGITS = 2,
  parameter int WIDTH    = 7,
  localparam int CW      = $clog2(N_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  input  logic             clear,
  input  logic             load_first,
  output logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] MAX_CNT = CW'(N_DIGITS);

  logic [WIDTH-1:0] times_ten_plus;

  // acc*10 + d without a multiplier; cannot overflow while count < N_DIGITS.
  assign times_ten_plus = (value << 3) + (value << 1) + WIDTH'(digit);

  // Accumulator and digit counter; digits beyond N_DIGITS are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (load_first) begin
      value <= WIDTH'(digit);
      count <= CW'(1);
    end else if (digit_en && (count < MAX_CNT)) begin
      value <= times_ten_plus;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/module_control_operandos.sv
// Sequences keypad entry of operands A and B, starts the multiplier,
// waits for its result and holds the product for display.
module module_control_operandos
  import pkg_multiplicador::*;
#(
  parameter int N_DIGITS = 2,
  parameter int WIDTH    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dato_listo_i,
  input  logic [3:0]         dato_i,
  input  logic               mult_done_i,
  input  logic [2*WIDTH-1:0] producto_i,
  output logic [WIDTH-1:0]   op_a_o,
  output logic [WIDTH-1:0]   op_b_o,
  output logic               start_o,
  output logic [2*WIDTH-1:0] producto_o,
  output logic               valido_o,
  output logic [WIDTH-1:0]   display_o,
  output logic [2:0]         estado_o
);

  localparam int CW = $clog2(N_DIGITS + 1);

  estado_t          state, state_next;
  logic [WIDTH-1:0] acc_a, acc_b;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             is_digit, is_clear, is_enter;
  logic             a_digit, a_clear, a_load, b_digit, b_clear;
  logic             latch_prod, clr_valido;

  assign is_digit = dato_listo_i && (dato_i <= 4'd9);
  assign is_clear = dato_listo_i && (dato_i == TECLA_CLEAR);
  assign is_enter = dato_listo_i && (dato_i == TECLA_ENTER);

  module_acum_decimal #(.N_DIGITS(N_DIGITS), .WIDTH(WIDTH)) u_acum_a (
    .clk        (clk),
    .rst        (rst),
    .digit_en   (a_digit),
    .digit      (dato_i),
    .clear      (a_clear),
    .load_first (a_load),
    .value      (acc_a),
    .count      (cnt_a)
  );

  module_acum_decimal #(.N_DIGITS(N_DIGITS), .WIDTH(WIDTH)) u_acum_b (
    .clk        (clk),
    .rst        (rst),
    .digit_en   (b_digit),
    .digit      (dato_i),
    .clear      (b_clear),
    .load_first (1'b0),
    .value      (acc_b),
    .count      (cnt_b)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CAPT_A;
    else     state <= state_next;
  end

  // Next state and accumulator/product controls from the current key strobe.
  always_comb begin
    state_next = state;
    a_digit    = 1'b0;
    a_clear    = 1'b0;
    a_load     = 1'b0;
    b_digit    = 1'b0;
    b_clear    = 1'b0;
    latch_prod = 1'b0;
    clr_valido = 1'b0;
    case (state)
      CAPT_A: begin
        if (is_digit) a_digit = 1'b1;
        else if (is_clear) a_clear = 1'b1;
        else if (is_enter && (cnt_a != '0)) begin
          b_clear    = 1'b1;
          state_next = CAPT_B;
        end
      end
      CAPT_B: begin
        if (is_digit) b_digit = 1'b1;
        else if (is_clear) begin
          if (cnt_b == '0) state_next = CAPT_A;
          else             b_clear    = 1'b1;
        end else if (is_enter && (cnt_b != '0)) state_next = START;
      end
      START: state_next = WAIT;
      WAIT: begin
        if (mult_done_i) begin
          latch_prod = 1'b1;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (is_digit) begin
          clr_valido = 1'b1;
          a_load     = 1'b1;
          state_next = CAPT_A;
        end else if (is_clear) begin
          clr_valido = 1'b1;
          a_clear    = 1'b1;
          state_next = CAPT_A;
        end
      end
      default: state_next = CAPT_A;
    endcase
  end

  // Product latch and freshness flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      producto_o <= '0;
      valido_o   <= 1'b0;
    end else if (latch_prod) begin
      producto_o <= producto_i;
      valido_o   <= 1'b1;
    end else if (clr_valido) begin
      valido_o   <= 1'b0;
    end
  end

  // Display follows the operand in progress, or the product once shown.
  always_comb begin
    display_o = acc_b;
    case (state)
      CAPT_A:  display_o = acc_a;
      SHOW:    display_o = producto_o[WIDTH-1:0];
      default: display_o = acc_b;
    endcase
  end

  assign op_a_o   = acc_a;
  assign op_b_o   = acc_b;
  assign start_o  = (state == START);
  assign estado_o = state;

endmodule

// File: tb/tb_module_control_operandos.sv
// Self-checking bench for module_control_operandos: directed steps followed
// by random key traffic, all checked against a behavioural model.
module tb_module_control_operandos;

  localparam int N_DIGITS = 2;
  localparam int WIDTH    = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               dato_listo_i;
  logic [3:0]         dato_i;
  logic               mult_done_i;
  logic [2*WIDTH-1:0] producto_i;
  logic [WIDTH-1:0]   op_a_o, op_b_o, display_o;
  logic               start_o, valido_o;
  logic [2*WIDTH-1:0] producto_o;
  logic [2:0]         estado_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phase 0..4 = capture A, capture B, start, wait, show.
  int m_state, m_a, m_na, m_b, m_nb, m_prod;
  bit m_valid;

  always #5 clk = ~clk;

  module_control_operandos #(.N_DIGITS(N_DIGITS), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .dato_listo_i (dato_listo_i),
    .dato_i       (dato_i),
    .mult_done_i  (mult_done_i),
    .producto_i   (producto_i),
    .op_a_o       (op_a_o),
    .op_b_o       (op_b_o),
    .start_o      (start_o),
    .producto_o   (producto_o),
    .valido_o     (valido_o),
    .display_o    (display_o),
    .estado_o     (estado_o)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_prod = 0; m_valid = 0;
  endtask

  task automatic modelStep(input bit s, input int k, input bit d, input int p);
    case (m_state)
      0: if (s) begin
        if (k <= 9) begin
          if (m_na < N_DIGITS) begin m_a = m_a * 10 + k; m_na++; end
        end else if (k == 10) begin
          m_a = 0; m_na = 0;
        end else if (k == 11 && m_na > 0) begin
          m_b = 0; m_nb = 0; m_state = 1;
        end
      end
      1: if (s) begin
        if (k <= 9) begin
          if (m_nb < N_DIGITS) begin m_b = m_b * 10 + k; m_nb++; end
        end else if (k == 10) begin
          if (m_nb == 0) m_state = 0;
          else begin m_b = 0; m_nb = 0; end
        end else if (k == 11 && m_nb > 0) begin
          m_state = 2;
        end
      end
      2: m_state = 3;
      3: if (d) begin m_prod = p; m_valid = 1; m_state = 4; end
      4: if (s) begin
        if (k <= 9) begin
          m_valid = 0; m_a = k; m_na = 1; m_state = 0;
        end else if (k == 10) begin
          m_valid = 0; m_a = 0; m_na = 0; m_state = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic checkOutput();
    int exp_disp;
    if (m_state == 0)      exp_disp = m_a;
    else if (m_state == 4) exp_disp = m_prod % (1 << WIDTH);
    else                   exp_disp = m_b;
    checkVal("op_a", op_a_o, m_a);
    checkVal("op_b", op_b_o, m_b);
    checkVal("start", start_o, (m_state == 2) ? 1 : 0);
    checkVal("producto", producto_o, m_prod);
    checkVal("valido", valido_o, m_valid);
    checkVal("display", display_o, exp_disp);
    checkVal("estado", estado_o, m_state);
  endtask

  // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
  task automatic applyStimulus(input bit s, input int k, input bit d, input int p);
    dato_listo_i = s;
    dato_i       = 4'(k);
    mult_done_i  = d;
    producto_i   = (2*WIDTH)'(p);
    @(negedge clk);
    modelStep(s, k, d, p);
    checkOutput();
    dato_listo_i = 1'b0;
    mult_done_i  = 1'b0;
  endtask

  task automatic pressKey(input int k);
    applyStimulus(1'b1, k, 1'b0, 0);
  endtask

  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k, r;
    bit s, d;
    rst = 1'b1; dato_listo_i = 1'b0; dato_i = 4'd0; mult_done_i = 1'b0; producto_i = '0;
    modelReset();
    @(negedge clk);
    checkOutput();
    rst = 1'b0;

    // Basic operation: 12 * 34.
    pressKey(1); pressKey(2); pressKey(11); pressKey(3); pressKey(4); pressKey(11);
    checkVal("start_after_enter", start_o, 1);
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkVal("start_one_cycle", start_o, 0);
    // Keys during WAIT are ignored, including one coinciding with done.
    pressKey(5); pressKey(11); pressKey(10);
    applyStimulus(1'b1, 7, 1'b1, 408);
    checkVal("prod_408", producto_o, 408);
    checkVal("op_a_frozen", op_a_o, 12);
    pressKey(11);
    // New digit in SHOW restarts A with that digit.
    pressKey(3);
    // Saturation at N_DIGITS.
    pressKey(10); pressKey(9); pressKey(9); pressKey(9);
    checkVal("display_99", display_o, 99);
    // Enter on empty A, then clear mid-entry.
    pressKey(10); pressKey(11); pressKey(5); pressKey(10); pressKey(7);
    checkVal("a_after_clear", op_a_o, 7);
    // Stray done outside WAIT and ignored codes.
    applyStimulus(1'b0, 0, 1'b1, 500);
    pressKey(12); pressKey(15);
    // Clear on empty B returns to A keeping A.
    pressKey(11); pressKey(10);
    // Reset asynchronously while waiting for the multiplier.
    pressKey(11); pressKey(8); pressKey(11);
    applyStimulus(1'b0, 0, 1'b0, 0);
    asyncReset();
    applyStimulus(1'b0, 0, 1'b1, 999);
    checkVal("late_done_ignored", producto_o, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      if (r < 12)      k = $urandom_range(0, 9);
      else if (r < 14) k = 10;
      else if (r < 18) k = 11;
      else             k = $urandom_range(12, 15);
      if (m_state == 3) d = ($urandom_range(0, 3) == 0);
      else              d = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) asyncReset();
      else applyStimulus(s, k, d, $urandom_range(0, (1 << (2*WIDTH)) - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
